// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter:
// FSM encoding, timeout defaults and the latched transaction bundle.
package sram_arb_pkg;

    // Width of the WAIT-state cycle counter
    localparam int CNT_W = 4;

    // Default number of WAIT cycles before a transaction is aborted
    localparam int TIMEOUT_DEF = 15;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [CNT_W-1:0] cnt_t;

    // Transaction captured at grant time
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        id;
    } xact_t;

    // Convert an integer timeout into the counter's width
    function automatic cnt_t cnt_limit(input int t);
        return cnt_t'(t);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not
// win last time is chosen, otherwise the lone requester wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

    // Pick a port from the current requests and the previous winner
    always_comb begin
        valid = req0 | req1;
        grant = (req0 & req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single SRAM controller.
// One transaction at a time: grant, issue strobe, wait, ack.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData,
    input  logic        mem_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam cnt_t TO_LIM = cnt_limit(TIMEOUT);

    logic [1:0]  state_q, state_d;
    xact_t       xact_q, xact_d;
    logic        last_q, last_d;
    cnt_t        cnt_q, cnt_d;
    cnt_t        cnt_nxt;
    logic [31:0] rdata_q, rdata_d;
    logic        terr_q, terr_d;
    logic        pick_vld;
    logic        pick_id;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .valid      (pick_vld),
        .grant      (pick_id)
    );

    // Next-state logic for the transaction FSM and its datapath
    always_comb begin
        state_d = state_q;
        xact_d  = xact_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        terr_d  = terr_q;
        cnt_nxt = cnt_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    xact_d.id    = pick_id;
                    xact_d.we    = pick_id ? we1 : we0;
                    xact_d.addr  = pick_id ? addr1 : addr0;
                    xact_d.wdata = pick_id ? wdata1 : wdata0;
                    last_d       = pick_id;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    if (!xact_q.we) begin
                        rdata_d = mem_readData;
                    end
                    state_d = ST_DONE;
                end else if (cnt_nxt == TO_LIM) begin
                    cnt_d   = cnt_nxt;
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xact_q  <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xact_q  <= xact_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy          = (state_q != ST_IDLE);
        mem_wr_en     = (state_q == ST_ISSUE) & xact_q.we;
        mem_rd_en     = (state_q == ST_ISSUE) & ~xact_q.we;
        ack0          = (state_q == ST_DONE) & ~xact_q.id;
        ack1          = (state_q == ST_DONE) & xact_q.id;
        mem_address   = xact_q.addr;
        mem_writeData = xact_q.wdata;
        rdata         = rdata_q;
        timeout_err   = terr_q;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM controller model, transaction-level
// reference model checked every cycle, plus directed scenarios.
module tb_sram_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic        mem_wr_en, mem_rd_en;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_ready;
    logic        busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sram_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .ack0          (ack0),
        .ack1          (ack1),
        .rdata         (rdata),
        .mem_wr_en     (mem_wr_en),
        .mem_rd_en     (mem_rd_en),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // SRAM controller model: 5 busy states for a write, 6 for a read,
    // ready high in the last one.
    bit          sram_off = 1'b0;
    logic [31:0] sram_mem [64];
    int          s_cnt  = 0;
    logic [31:0] s_addr = '0;

    initial begin
        for (int i = 0; i < 64; i++) sram_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            s_cnt <= 0;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
        end else if (!sram_off && (mem_wr_en || mem_rd_en)) begin
            s_cnt  <= mem_wr_en ? 5 : 6;
            s_addr <= mem_address;
            if (mem_wr_en) sram_mem[mem_address[7:2]] <= mem_writeData;
        end
    end

    assign mem_ready    = !sram_off && (s_cnt == 1);
    assign mem_readData = sram_mem[s_addr[7:2]];

    // Reference model: one transaction at a time, described by its
    // cycle offset from the grant and a fixed completion offset.
    logic [31:0] ref_mem [64];
    bit          m_act   = 0;
    int          m_t     = 0;
    int          m_done  = 0;
    bit          m_to    = 0;
    bit          m_port  = 0;
    bit          m_last  = 1;
    bit          m_we    = 0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    bit          m_terr  = 0;
    bit          m_p;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_act   <= 0;
            m_last  <= 1;
            m_rdata <= '0;
            m_terr  <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_we    <= 0;
        end else if (!m_act) begin
            if (req0 || req1) begin
                m_p = (req0 && req1) ? !m_last : req1;
                m_act   <= 1;
                m_t     <= 1;
                m_port  <= m_p;
                m_last  <= m_p;
                m_we    <= m_p ? we1 : we0;
                m_addr  <= m_p ? addr1 : addr0;
                m_wdata <= m_p ? wdata1 : wdata0;
                m_to    <= sram_off;
                if (sram_off) m_done <= TO + 2;
                else m_done <= (m_p ? we1 : we0) ? 7 : 8;
                if (!sram_off && (m_p ? we1 : we0))
                    ref_mem[m_p ? addr1[7:2] : addr0[7:2]] <=
                        m_p ? wdata1 : wdata0;
            end
        end else if (m_t == m_done) begin
            m_act <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == m_done) begin
                if (m_to) m_terr <= 1;
                else if (!m_we) m_rdata <= ref_mem[m_addr[7:2]];
            end
        end
    end

    // Per-cycle compare of every DUT output against the model
    bit chk_en = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_act));
            check("mem_wr_en", 32'(mem_wr_en),
                  32'(m_act && m_t == 1 && m_we));
            check("mem_rd_en", 32'(mem_rd_en),
                  32'(m_act && m_t == 1 && !m_we));
            check("ack0", 32'(ack0),
                  32'(m_act && m_t == m_done && !m_port));
            check("ack1", 32'(ack1),
                  32'(m_act && m_t == m_done && m_port));
            check("rdata", rdata, m_rdata);
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            check("mem_address", mem_address, m_addr);
            check("mem_writeData", mem_writeData, m_wdata);
        end
    end

    // Pulse counters sampled well away from both clock edges
    int wr_cnt = 0, rd_cnt = 0, a0_cnt = 0, a1_cnt = 0;

    always @(posedge clk) begin
        #2;
        if (mem_wr_en === 1'b1) wr_cnt++;
        if (mem_rd_en === 1'b1) rd_cnt++;
        if (ack0 === 1'b1) a0_cnt++;
        if (ack1 === 1'b1) a1_cnt++;
    end

    // Hold request p until its ack, then drop it; returns ack cycle
    task automatic serve(input bit p, output int ac);
        ac = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((p ? ack1 : ack0) === 1'b1) begin
                ac = cyc;
                break;
            end
        end
        if (p) req1 = 1'b0;
        else req0 = 1'b0;
        if (ac < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL serve%0d: got no ack, required ack within 60", p);
        end
    endtask

    task automatic drive(input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
        if (p) begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end
    endtask

    task automatic do_txn(input bit p, input bit we, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        int s, ac;
        @(negedge clk);
        drive(p, we, a, d);
        s = cyc;
        serve(p, ac);
        lat = ac - s;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish by 100us");
        $fatal(1);
    end

    initial begin
        int lat, s, a0, a1, w0, r0, c0, c1;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({ack1, ack0}), 32'd0);
        check("rst_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);

        // Single write from port 0
        w0 = wr_cnt; r0 = rd_cnt; c1 = a1_cnt;
        do_txn(0, 1, 32'h10, 32'hA5A5_1234, lat);
        check("wr_latency", 32'(lat), 32'd7);
        check("wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check("wr_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("wr_no_ack1", 32'(a1_cnt - c1), 32'd0);

        // Read back from port 1
        w0 = wr_cnt; r0 = rd_cnt; c0 = a0_cnt;
        do_txn(1, 0, 32'h10, 32'h0, lat);
        check("rd_latency", 32'(lat), 32'd8);
        check("rd_data", rdata, 32'hA5A5_1234);
        check("rd_pulses", 32'(rd_cnt - r0), 32'd1);
        check("rd_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("rd_no_ack0", 32'(a0_cnt - c0), 32'd0);

        // Tie after reset: port 0 first
        pulse_rst();
        check("tie_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        drive(0, 1, 32'h20, 32'h1111_2222);
        drive(1, 0, 32'h10, 32'h0);
        s = cyc;
        fork
            serve(0, a0);
            serve(1, a1);
        join
        check("tie1_p0", 32'(a0 - s), 32'd7);
        check("tie1_p1", 32'(a1 - s), 32'd16);
        check("tie1_rdata", rdata, 32'hA5A5_1234);

        // Second tie: last winner was port 1, so port 0 again
        @(negedge clk);
        drive(0, 0, 32'h20, 32'h0);
        drive(1, 1, 32'h30, 32'h0000_3333);
        s = cyc;
        fork
            serve(0, a0);
            serve(1, a1);
        join
        check("tie2_p0", 32'(a0 - s), 32'd8);
        check("tie2_p1", 32'(a1 - s), 32'd16);
        check("tie2_rdata", rdata, 32'h1111_2222);

        // Port 0 alone, then a tie must go to port 1
        do_txn(0, 1, 32'h34, 32'h0000_4444, lat);
        check("solo_latency", 32'(lat), 32'd7);
        @(negedge clk);
        drive(0, 0, 32'h30, 32'h0);
        drive(1, 0, 32'h34, 32'h0);
        s = cyc;
        fork
            serve(0, a0);
            serve(1, a1);
        join
        check("tie3_p1", 32'(a1 - s), 32'd8);
        check("tie3_p0", 32'(a0 - s), 32'd17);
        check("tie3_rdata", rdata, 32'h0000_3333);

        // Controller never ready: abort after TIMEOUT wait cycles
        @(negedge clk);
        sram_off = 1;
        do_txn(0, 0, 32'h10, 32'h0, lat);
        check("to_latency", 32'(lat), 32'd17);
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_rdata", rdata, 32'h0000_3333);
        sram_off = 0;
        do_txn(1, 1, 32'h38, 32'h0000_7777, lat);
        check("post_to_latency", 32'(lat), 32'd7);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset during WAIT of a read
        c1 = a1_cnt;
        @(negedge clk);
        drive(1, 0, 32'h20, 32'h0);
        s = cyc;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_acks", 32'({ack1, ack0}), 32'd0);
        check("ab_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("ab_rdata", rdata, 32'd0);
        check("ab_terr", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("ab_no_ack", 32'(a1_cnt - c1), 32'd0);

        // Port 1 arrives during port 0 WAIT and waits for IDLE
        @(negedge clk);
        drive(0, 1, 32'h3C, 32'h0000_9999);
        s = cyc;
        fork
            serve(0, a0);
            begin
                repeat (3) @(negedge clk);
                drive(1, 0, 32'h3C, 32'h0);
                serve(1, a1);
            end
        join
        check("late_p0", 32'(a0 - s), 32'd7);
        check("late_p1", 32'(a1 - s), 32'd16);
        check("late_rdata", rdata, 32'h0000_9999);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles in WAIT before abort.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1  requester N transaction request, held until ackN.
REQ-005 SHALL have ports we0/we1  input  1  1=write, 0=read, valid while reqN.
REQ-006 SHALL have ports addr0/addr1  input  32  byte address, valid while reqN.
REQ-007 SHALL have ports wdata0/wdata1  input  32  write data, valid while reqN.
REQ-008 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse to requester N.
REQ-009 SHALL have port rdata  output  32  read data, valid during ack of a read.
REQ-010 SHALL have ports mem_wr_en/mem_rd_en  output  1  start strobes to SRAM controller.
REQ-011 SHALL have ports mem_address/mem_writeData  output  32  address/data to SRAM controller.
REQ-012 SHALL have port mem_readData  input  32  read data from SRAM controller.
REQ-013 SHALL have port mem_ready  input  1  SRAM controller ready (high when next state is idle).
REQ-014 SHALL have ports busy  output  1  (state != IDLE) and timeout_err  output  1  sticky abort flag.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, all transitions on rising clk.
REQ-016 IDLE: if req0|req1, SHALL grant one port, latch its we/addr/wdata and grant id into registers, go ISSUE; else stay.
REQ-017 Arbitration SHALL be round-robin: both requesting -> grant port != last_grant; one requesting -> grant it; last_grant updates on each grant; last_grant resets to 1 (port 0 wins first tie).
REQ-018 ISSUE: SHALL assert exactly one of mem_wr_en/mem_rd_en (per latched we) for exactly one cycle, then go WAIT.
REQ-019 mem_address/mem_writeData SHALL be driven from the latched registers, stable from ISSUE through DONE.
REQ-020 WAIT: on mem_ready=1 SHALL capture mem_readData into rdata (reads only) and go DONE; mem_ready SHALL NOT be sampled in ISSUE.
REQ-021 WAIT SHALL count cycles with a 4-bit counter cleared on entry; when count reaches TIMEOUT without mem_ready, SHALL set timeout_err, go DONE, leave rdata unchanged.
REQ-022 DONE: SHALL pulse ack of granted port for exactly one cycle, then go IDLE; never both acks high.
REQ-023 Latency from IDLE grant cycle to ack: write 7 cycles, read 8 cycles (controller 5/6-state sequences).
REQ-024 Requests arriving or changing while not IDLE SHALL be ignored until next IDLE; req deasserted before grant SHALL be dropped silently.
REQ-025 A req still high in IDLE after its ack SHALL be treated as a new transaction.
REQ-026 rdata SHALL hold its value between reads; writes SHALL NOT modify it.
REQ-027 mem_wr_en and mem_rd_en SHALL never be high simultaneously and SHALL be low outside ISSUE.

Reset
REQ-028 rst SHALL force: state IDLE, ack0/ack1=0, mem_wr_en/mem_rd_en=0, mem_address/mem_writeData=0, rdata=0, timeout_err=0, counter=0, last_grant=1.
REQ-029 rst asserted mid-transaction SHALL abort it with no ack; SRAM controller shares the same rst.
REQ-030 timeout_err SHALL clear only on rst.

Structure
REQ-031 State encoding, TIMEOUT default and counter width SHALL live in shared package sram_arb_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick2 (inputs req0, req1, last_grant; outputs valid, grant id), combinational.

Verification
REQ-033 req0 write addr 0x10 data 0xA5A5_1234, SRAM controller model attached -> single mem_wr_en pulse, ack0 7 cycles after grant, ack1 never.
REQ-034 req1 read addr 0x10 after REQ-033 write -> mem_rd_en pulse, ack1 8 cycles after grant, rdata=0xA5A5_1234.
REQ-035 req0 and req1 high in same IDLE cycle after reset -> port 0 served first, port 1 next; repeated tie alternates.
REQ-036 mem_ready tied 0 -> timeout_err=1, ack after TIMEOUT=15 WAIT cycles, rdata unchanged, next request still served.
REQ-037 rst asserted in WAIT of a read -> next cycle state IDLE, no ack, enables 0, rdata=0.
REQ-038 req1 asserted during port-0 WAIT -> ignored until IDLE, then granted; mem enables never overlap.
